alu_mul_seq: RTL

//  Multi-cycle 16x16 -> 32-bit unsigned multiply sequencer built on the shared 16-bit ALU.

---
 rtl/alu_mul_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16->32 unsigned shift-and-add multiplier that borrows the shared ALU for one add per cycle.
module alu_mul_seq #(
  parameter int DATA_W    = 16,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [DATA_W-1:0]   i_data_a,
  input  logic [DATA_W-1:0]   i_data_b,
  input  logic                i_ack,
  input  logic                i_flush,
  output logic                o_ready,
  output logic                o_valid,
  output logic [2*DATA_W-1:0] o_prod,
  output logic                o_alu_req,
  output logic [3:0]          o_alu_ctrl,
  output logic [DATA_W-1:0]   o_alu_a,
  output logic [DATA_W-1:0]   o_alu_b,
  output logic                o_alu_carry,
  input  logic [DATA_W-1:0]   i_alu_data,
  input  logic [3:0]          i_alu_flag
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [3:0] ALU_ADD = 4'h0;
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic [DATA_W:0]   sum17;
  logic              zero_op, unused_flags;
  assign unused_flags = ^i_alu_flag[2:0];
  // ALU carry-out becomes bit 16 of the partial sum before the right shift
  assign sum17   = {i_alu_flag[3], i_alu_data};
  assign zero_op = SKIP_ZERO && (i_data_a == '0 || i_data_b == '0);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    if (i_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      mcand_d = '0;
      p_hi_d  = '0;
      p_lo_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          state_d = zero_op ? DONE : RUN;
          cnt_d   = '0;
          mcand_d = i_data_a;
          p_hi_d  = '0;
          p_lo_d  = zero_op ? '0 : i_data_b;
        end
        RUN: begin
          p_hi_d  = sum17[DATA_W:1];
          p_lo_d  = {sum17[0], p_lo_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == 4'd15) ? DONE : RUN;
        end
        DONE:    state_d = i_ack ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
    end
  end
  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_alu_req   = (state_q == RUN);
  assign o_prod      = o_valid ? {p_hi_q, p_lo_q} : '0;
  assign o_alu_ctrl  = ALU_ADD;
  assign o_alu_carry = 1'b0;
  assign o_alu_a     = o_alu_req ? p_hi_q : '0;
  assign o_alu_b     = (o_alu_req && p_lo_q[0]) ? mcand_q : '0;
endmodule
